// File: rtl/systolic_feeder_if.sv
// Upstream channels of the systolic feeder: weight rows (w_*) and input vectors (x_*).
// The feeder takes the slave modport; the upstream producer takes master.
interface systolic_feeder_if #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int DATA_WIDTH = 16
);
  logic                       w_valid;
  logic                       w_ready;
  logic [COLS*DATA_WIDTH-1:0] w_data;
  logic                       x_valid;
  logic                       x_ready;
  logic [ROWS*DATA_WIDTH-1:0] x_data;
  logic                       x_last;

  modport master (
    output w_valid, w_data, x_valid, x_data, x_last,
    input  w_ready, x_ready
  );

  modport slave (
    input  w_valid, w_data, x_valid, x_data, x_last,
    output w_ready, x_ready
  );
endinterface

// File: rtl/systolic_feeder.sv
// West/north edge driver for a ROWS x COLS PE array: buffers a weight tile, shifts it
// down the column chains with per-column skew, fires the switch wave, then streams skewed inputs.
module systolic_feeder #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  systolic_feeder_if.slave           up,
  output logic [COLS*DATA_WIDTH-1:0] sys_weight,
  output logic [COLS-1:0]            sys_accept_w,
  output logic [ROWS*DATA_WIDTH-1:0] sys_input,
  output logic [ROWS-1:0]            sys_valid,
  output logic [ROWS-1:0]            sys_switch,
  output logic                       busy,
  output logic                       done
);
  localparam int DW        = DATA_WIDTH;
  localparam int SHIFT_LEN = ROWS + COLS - 1;
  localparam int CW        = $clog2(SHIFT_LEN + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(SHIFT_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(ROWS - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((ROWS > 1) ? ROWS - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_CAPTURE,
    S_W_SHIFT,
    S_SWITCH,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [COLS*DW-1:0]   buf_q [ROWS];
  logic                 w_ready_q, x_ready_q, busy_q, done_q, done_d;
  logic [COLS*DW-1:0]   weight_q, weight_d;
  logic [COLS-1:0]      accept_q, accept_d;
  logic [ROWS*DW-1:0]   xdat_q [ROWS];
  logic [ROWS-1:0]      xvld_q, sw_q;
  logic                 w_hs, x_hs;
  logic [CW-1:0]        wr_idx;

  assign w_hs   = up.w_valid & w_ready_q;
  assign x_hs   = up.x_valid & x_ready_q;
  assign wr_idx = (state_q == S_IDLE) ? '0 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_hs) begin
          state_d = (ROWS == 1) ? S_W_SHIFT : S_W_CAPTURE;
          cnt_d   = (ROWS == 1) ? '0 : CW'(1);
        end
      end
      S_W_CAPTURE: begin
        if (w_hs) begin
          if (cnt_q == CAP_LAST) begin
            state_d = S_W_SHIFT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_W_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = S_SWITCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SWITCH: state_d = S_STREAM;
      S_STREAM: begin
        if (x_hs && up.x_last) begin
          // With a single row the last vector is already on the edge next cycle.
          if (ROWS == 1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Column c loads buf[t-c] while 0 <= t-c < ROWS; bottom-row beat goes first.
  always_comb begin
    weight_d = '0;
    accept_d = '0;
    if (state_q == S_W_SHIFT) begin
      for (int c = 0; c < COLS; c++) begin
        for (int k = 0; k < ROWS; k++) begin
          if (int'(cnt_q) == k + c) begin
            accept_d[c]          = 1'b1;
            weight_d[c*DW +: DW] = buf_q[k][c*DW +: DW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      w_ready_q <= 1'b0;
      x_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      weight_q  <= '0;
      accept_q  <= '0;
      xvld_q    <= '0;
      sw_q      <= '0;
      for (int k = 0; k < ROWS; k++) begin
        buf_q[k]  <= '0;
        xdat_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_ready_q <= (state_d == S_IDLE) || (state_d == S_W_CAPTURE);
      x_ready_q <= (state_d == S_STREAM);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
      weight_q  <= weight_d;
      accept_q  <= accept_d;
      for (int k = 0; k < ROWS; k++) begin
        if (w_hs && wr_idx == CW'(k)) buf_q[k] <= up.w_data;
      end
      // Stage r of the delay lines feeds row r; bubbles travel as zero data.
      xvld_q[0] <= x_hs;
      xdat_q[0] <= x_hs ? up.x_data : '0;
      sw_q[0]   <= (state_q == S_SWITCH);
      for (int r = 1; r < ROWS; r++) begin
        xvld_q[r] <= xvld_q[r-1];
        xdat_q[r] <= xdat_q[r-1];
        sw_q[r]   <= sw_q[r-1];
      end
    end
  end

  always_comb begin
    sys_input = '0;
    for (int r = 0; r < ROWS; r++) begin
      sys_input[r*DW +: DW] = xdat_q[r][r*DW +: DW];
    end
  end

  assign up.w_ready   = w_ready_q;
  assign up.x_ready   = x_ready_q;
  assign sys_weight   = weight_q;
  assign sys_accept_w = accept_q;
  assign sys_valid    = xvld_q;
  assign sys_switch   = sw_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (ROWS=COLS=2): per-cycle expectation table for the
// weight/switch phase, a per-row scoreboard for the skewed input stream, and hand-written corner sequences.
module tb_systolic_feeder;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [COLS*DW-1:0]   sys_weight;
  logic [COLS-1:0]      sys_accept_w;
  logic [ROWS*DW-1:0]   sys_input;
  logic [ROWS-1:0]      sys_valid;
  logic [ROWS-1:0]      sys_switch;
  logic                 busy;
  logic                 done;

  systolic_feeder_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) bus ();

  systolic_feeder #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .up           (bus.slave),
    .sys_weight   (sys_weight),
    .sys_accept_w (sys_accept_w),
    .sys_input    (sys_input),
    .sys_valid    (sys_valid),
    .sys_switch   (sys_switch),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  acc;
    logic [31:0] wt;
    logic [1:0]  sw;
    logic        busy;
    logic        wr;
    logic        xr;
  } tbl_t;

  typedef struct {
    logic        v;
    logic [15:0] r0;
    logic [15:0] r1;
    logic        last;
  } stim_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  tbl_t  tbl [8];
  stim_t stim [$];
  exp_t  q0 [$];
  exp_t  q1 [$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  bit    mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_check();
    logic [16:0] e0, e1;
    e0 = '0;
    e1 = '0;
    if (q0.size() > 0 && q0[0].due == cyc) begin
      e0 = {1'b1, q0[0].data};
      void'(q0.pop_front());
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e1 = {1'b1, q1[0].data};
      void'(q1.pop_front());
    end
    chk("row0_valid_input", 64'({sys_valid[0], sys_input[15:0]}), 64'(e0));
    chk("row1_valid_input", 64'({sys_valid[1], sys_input[31:16]}), 64'(e1));
  endtask

  always @(negedge clk) if (mon_en) mon_check();

  task automatic chk_tbl(input int k);
    chk($sformatf("accept_w@c%0d", k), 64'(sys_accept_w), 64'(tbl[k].acc));
    chk($sformatf("weight@c%0d", k), 64'(sys_weight), 64'(tbl[k].wt));
    chk($sformatf("switch@c%0d", k), 64'(sys_switch), 64'(tbl[k].sw));
    chk($sformatf("busy@c%0d", k), 64'(busy), 64'(tbl[k].busy));
    chk($sformatf("w_ready@c%0d", k), 64'(bus.w_ready), 64'(tbl[k].wr));
    if (k < 7) chk($sformatf("x_ready@c%0d", k), 64'(bus.x_ready), 64'(tbl[k].xr));
    if (k > 0) chk($sformatf("done_quiet@c%0d", k), 64'(done), 64'(0));
  endtask

  // Starts in a cycle with w_ready=1; returns in tile cycle 6 (first STREAM cycle).
  task automatic load_weights();
    for (int k = 0; k < 6; k++) begin
      chk_tbl(k);
      bus.w_valid = (k < 2);
      bus.w_data  = (k == 0) ? {16'd4, 16'd3} : {16'd2, 16'd1};
      step();
    end
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
  endtask

  // Full tile using the stim queue; returns in the done cycle.
  task automatic run_tile();
    int k, h, d;
    load_weights();
    k = 6;
    h = -1;
    foreach (stim[i]) begin
      if (k < 8) chk_tbl(k);
      chk("x_ready_stream", 64'(bus.x_ready), 64'(1));
      bus.x_valid = stim[i].v;
      bus.x_data  = {stim[i].r1, stim[i].r0};
      bus.x_last  = stim[i].last;
      if (stim[i].v) begin
        q0.push_back('{due: cyc + 1, data: stim[i].r0});
        q1.push_back('{due: cyc + 2, data: stim[i].r1});
        if (stim[i].last) h = k;
      end
      step();
      k++;
    end
    bus.x_valid = 1'b0;
    bus.x_last  = 1'b0;
    bus.x_data  = '0;
    d = k - h;
    while (done !== 1'b1 && d < 8) begin
      if (k < 8) chk_tbl(k);
      step();
      k++;
      d++;
    end
    chk("done_latency", 64'(d), 64'(2));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("w_ready_at_done", 64'(bus.w_ready), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_weight"}, 64'(sys_weight), 64'(0));
    chk({tag, "_accept_w"}, 64'(sys_accept_w), 64'(0));
    chk({tag, "_input"}, 64'(sys_input), 64'(0));
    chk({tag, "_valid"}, 64'(sys_valid), 64'(0));
    chk({tag, "_switch"}, 64'(sys_switch), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_w_ready"}, 64'(bus.w_ready), 64'(0));
    chk({tag, "_x_ready"}, 64'(bus.x_ready), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            acc     wt                    sw     busy  wr    xr
    tbl[0] = '{2'b00, 32'h0,                2'b00, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{2'b00, 32'h0,                2'b00, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{2'b00, 32'h0,                2'b00, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{2'b01, {16'd0, 16'd3},       2'b00, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{2'b11, {16'd4, 16'd1},       2'b00, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{2'b10, {16'd2, 16'd0},       2'b00, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{2'b00, 32'h0,                2'b01, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{2'b00, 32'h0,                2'b10, 1'b1, 1'b0, 1'b1};

    rst         = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.x_last  = 1'b0;

    // Reset held with random upstream activity.
    for (int i = 0; i < 4; i++) begin
      bus.w_valid = 1'($urandom_range(1));
      bus.w_data  = 32'($urandom);
      bus.x_valid = 1'($urandom_range(1));
      bus.x_data  = 32'($urandom);
      bus.x_last  = 1'($urandom_range(1));
      step();
      mon_en = 1'b1;
      chk_all_zero("reset");
    end
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.x_last  = 1'b0;
    rst = 1'b1;
    chk("w_ready_before_release", 64'(bus.w_ready), 64'(0));
    step();
    chk("w_ready_after_release", 64'(bus.w_ready), 64'(1));

    // Tile 1: two vectors, no stalls.
    stim.delete();
    stim.push_back('{v: 1'b1, r0: 16'd5, r1: 16'd6, last: 1'b0});
    stim.push_back('{v: 1'b1, r0: 16'd7, r1: 16'd8, last: 1'b1});
    run_tile();

    // Tile 2 back-to-back from the done cycle, with one bubble and signed extremes.
    stim.delete();
    stim.push_back('{v: 1'b1, r0: 16'hFFFB, r1: 16'h7FFF, last: 1'b0});
    stim.push_back('{v: 1'b0, r0: 16'hDEAD, r1: 16'hBEEF, last: 1'b1});
    stim.push_back('{v: 1'b1, r0: 16'h8000, r1: 16'h0001, last: 1'b1});
    run_tile();
    step();
    chk("done_one_cycle", 64'(done), 64'(0));
    step();

    // Reset in the middle of STREAM.
    load_weights();
    chk("x_ready_midop", 64'(bus.x_ready), 64'(1));
    bus.x_valid = 1'b1;
    bus.x_data  = {16'd10, 16'd9};
    q0.push_back('{due: cyc + 1, data: 16'd9});
    step();
    bus.x_data = {16'd12, 16'd11};
    rst = 1'b0;
    step();
    q0.delete();
    q1.delete();
    chk_all_zero("midop_reset");
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    rst = 1'b1;
    step();
    chk("midop_no_done", 64'(done), 64'(0));
    chk("midop_w_ready", 64'(bus.w_ready), 64'(1));

    // Full tile after the mid-op reset, then a single-vector tile back-to-back.
    stim.delete();
    stim.push_back('{v: 1'b1, r0: 16'd5, r1: 16'd6, last: 1'b0});
    stim.push_back('{v: 1'b1, r0: 16'd7, r1: 16'd8, last: 1'b1});
    run_tile();
    stim.delete();
    stim.push_back('{v: 1'b1, r0: 16'h1234, r1: 16'hABCD, last: 1'b1});
    run_tile();
    step();
    chk("done_one_cycle_end", 64'(done), 64'(0));
    step();
    step();
    chk("scoreboard_drained", 64'(q0.size() + q1.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
